encoder_read_scheduler: RTL and testbench

//  Shares one I2C read master between NUM_CH rotation-motor PID channels. Round-robins 12-bit

---
 rtl/enc_sched_pkg.sv | 22 ++
 rtl/encoder_read_scheduler_rr_arbiter.sv | 35 +++
 rtl/encoder_read_scheduler.sv | 176 +++++++++++++++++
 tb/tb_encoder_read_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_sched_pkg.sv
// ----------------------------------------------------------------------------
// enc_sched_pkg
// Shared definitions for the encoder read scheduler: the scheduler state
// encoding, default I2C addresses of the angle encoders and the angle width.
// No ports; imported by encoder_read_scheduler and rr_arbiter.
// ----------------------------------------------------------------------------
package enc_sched_pkg;

    localparam int         ANGLE_W              = 12;
    localparam logic [6:0] ENC_DEV_ADDR_DEFAULT = 7'h36;
    localparam logic [7:0] ENC_REG_DEFAULT      = 8'h0C;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        DELIVER = 3'd4,
        GAP     = 3'd5
    } state_t;

endpackage

// File: rtl/encoder_read_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first requesting channel at or
// after the pointer, wrapping from NUM_CH-1 back to 0.
// Ports:
//   req   in  NUM_CH  request mask
//   ptr   in  SEL_W   channel to search from
//   grant out SEL_W   granted channel index (0 when nothing requests)
//   valid out 1       at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
    import enc_sched_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant,
    output logic              valid
);

    // Scan from the farthest candidate back to the pointer so that the last
    // assignment made is the closest requester at or after the pointer.
    always_comb begin
        grant = '0;
        valid = |req;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_CH]) begin
                grant = SEL_W'((int'(ptr) + i) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/encoder_read_scheduler.sv
// ----------------------------------------------------------------------------
// encoder_read_scheduler
// Shares one I2C read master between NUM_CH motor PID channels. Enabled
// channels are served round-robin; each read fetches the 12-bit raw angle of
// that channel's encoder, steers the bus mux with i2c_sel, and hands the
// result back as a latched angle plus a one-cycle rd_done pulse. NACKs and
// timeouts set a sticky per-channel err_flag.
//
// Optional build macro ENC_ERR_CNT_EN adds err_count, a saturating 8-bit
// error counter per channel.
//
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   ch_enable  [NUM_CH]     per-channel read request
//   err_clear  [NUM_CH]     pulse clears the matching err_flag bit
//   i2c_start               one-cycle launch pulse to the shared master
//   i2c_dev_addr/reg_addr   encoder device / raw-angle register address
//   i2c_sel    [SEL_W]      bus-mux select, held for the whole read
//   i2c_busy, i2c_done,
//   i2c_ack_err, i2c_rd_data  shared master status and read data
//   angle_out  [12*NUM_CH]  latched angle per channel, ch0 in [11:0]
//   rd_done    [NUM_CH]     one-cycle pulse, angle_out[ch] just updated
//   err_flag   [NUM_CH]     sticky NACK/timeout flag
//   active                  scheduler is not idle
//   err_count  [8*NUM_CH]   (ENC_ERR_CNT_EN only) per-channel error count
// ----------------------------------------------------------------------------
module encoder_read_scheduler
    import enc_sched_pkg::*;
#(
    parameter  int          NUM_CH       = 4,
    parameter  logic [6:0]  ENC_DEV_ADDR = ENC_DEV_ADDR_DEFAULT,
    parameter  logic [7:0]  ENC_REG      = ENC_REG_DEFAULT,
    parameter  logic [15:0] TIMEOUT_CYC  = 16'd50000,
    parameter  logic [7:0]  GAP_CYC      = 8'd16,
    localparam int          SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH-1:0]         err_clear,
    output logic                      i2c_start,
    output logic [6:0]                i2c_dev_addr,
    output logic [7:0]                i2c_reg_addr,
    output logic [SEL_W-1:0]          i2c_sel,
    input  logic                      i2c_busy,
    input  logic                      i2c_done,
    input  logic                      i2c_ack_err,
    input  logic [15:0]               i2c_rd_data,
    output logic [ANGLE_W*NUM_CH-1:0] angle_out,
    output logic [NUM_CH-1:0]         rd_done,
    output logic [NUM_CH-1:0]         err_flag,
    output logic                      active
`ifdef ENC_ERR_CNT_EN
    ,
    output logic [8*NUM_CH-1:0]       err_count
`endif
);

    state_t             state;
    state_t             next_state;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   rr_ptr;
    logic [15:0]        cnt;
    logic               ack_err_q;
    logic [NUM_CH-1:0]  err_set;
    logic [SEL_W-1:0]   grant;
    logic               grant_valid;
    logic               gap_last;
    logic               unused_rd_bits;

    // The encoder angle is 12 bits; the top nibble of the read word carries
    // nothing useful.
    assign unused_rd_bits = ^i2c_rd_data[15:12];

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (ch_enable),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    assign i2c_start    = (state == START);
    assign i2c_dev_addr = ENC_DEV_ADDR;
    assign i2c_reg_addr = ENC_REG;
    assign i2c_sel      = sel;
    assign active       = (state != IDLE);

    // A zero gap still spends one cycle in GAP.
    assign gap_last = (GAP_CYC == 8'd0) || (cnt == {8'd0, GAP_CYC - 8'd1});

    // Next-state logic plus the per-cycle rd_done pulse and error-set strobe.
    always_comb begin
        next_state = state;
        err_set    = '0;
        rd_done    = '0;
        case (state)
            IDLE: begin
                if (|ch_enable && !i2c_busy) next_state = ARB;
            end
            ARB: begin
                next_state = grant_valid ? START : IDLE;
            end
            START: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (i2c_done) begin
                    next_state = DELIVER;
                end else if (cnt == TIMEOUT_CYC - 16'd1) begin
                    err_set[sel] = 1'b1;
                    next_state   = GAP;
                end
            end
            DELIVER: begin
                if (ack_err_q) err_set[sel] = 1'b1;
                else           rd_done[sel] = 1'b1;
                next_state = GAP;
            end
            GAP: begin
                if (gap_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // One counter serves both the WAIT timeout and the GAP length; it
    // restarts from zero on every state change.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            ack_err_q <= 1'b0;
            angle_out <= '0;
            err_flag  <= '0;
        end else begin
            state <= next_state;
            cnt   <= (state != next_state) ? 16'd0 : cnt + 16'd1;

            if (state == ARB && grant_valid) begin
                sel    <= grant;
                rr_ptr <= (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + SEL_W'(1);
            end

            // The angle is written as i2c_done arrives so it is already
            // valid while rd_done pulses in DELIVER.
            if (state == WAIT && i2c_done) begin
                ack_err_q <= i2c_ack_err;
                if (!i2c_ack_err) begin
                    angle_out[int'(sel)*ANGLE_W +: ANGLE_W] <= i2c_rd_data[ANGLE_W-1:0];
                end
            end

            err_flag <= (err_flag & ~err_clear) | err_set;
        end
    end

`ifdef ENC_ERR_CNT_EN
    // Saturating error counters; a clear beats a simultaneous increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (err_clear[i]) begin
                    err_count[i*8 +: 8] <= 8'h00;
                end else if (err_set[i] && err_count[i*8 +: 8] != 8'hFF) begin
                    err_count[i*8 +: 8] <= err_count[i*8 +: 8] + 8'h01;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_encoder_read_scheduler.sv
// ----------------------------------------------------------------------------
// tb_encoder_read_scheduler
// Directed bench for encoder_read_scheduler with a stub I2C master. Stimulus
// queues the expected grant and delivery for every read; a monitor on the
// falling edge pops and compares whenever i2c_start or rd_done appears.
// ----------------------------------------------------------------------------
module tb_encoder_read_scheduler;

    localparam int          NUM_CH  = 4;
    localparam logic [15:0] TIMEOUT = 16'd40;
    localparam logic [7:0]  GAP     = 8'd4;

    typedef struct {
        logic [15:0] data;
        bit          ack;
        bit          mute;
        int          delay;
    } stub_t;

    typedef struct {
        int          ch;
        logic [11:0] angle;
    } done_t;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_CH-1:0]    ch_enable = '0;
    logic [NUM_CH-1:0]    err_clear = '0;
    logic                 i2c_start;
    logic [6:0]           i2c_dev_addr;
    logic [7:0]           i2c_reg_addr;
    logic [1:0]           i2c_sel;
    logic                 i2c_busy = 1'b0;
    logic                 i2c_done = 1'b0;
    logic                 i2c_ack_err = 1'b0;
    logic [15:0]          i2c_rd_data = '0;
    logic [12*NUM_CH-1:0] angle_out;
    logic [NUM_CH-1:0]    rd_done;
    logic [NUM_CH-1:0]    err_flag;
    logic                 active;
`ifdef ENC_ERR_CNT_EN
    logic [8*NUM_CH-1:0]  err_count;
`endif

    int    pass_count = 0;
    int    check_count = 0;
    int    cycle = 0;
    int    start_count = 0;
    int    last_start_cycle = 0;
    int    last_done_cycle = 0;
    bit    last_done_valid = 0;
    bit    gap_check_en = 0;
    int    stub_done_cycle = 0;

    stub_t stub_q[$];
    int    exp_start_q[$];
    done_t exp_done_q[$];

    encoder_read_scheduler #(
        .NUM_CH      (NUM_CH),
        .TIMEOUT_CYC (TIMEOUT),
        .GAP_CYC     (GAP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ch_enable    (ch_enable),
        .err_clear    (err_clear),
        .i2c_start    (i2c_start),
        .i2c_dev_addr (i2c_dev_addr),
        .i2c_reg_addr (i2c_reg_addr),
        .i2c_sel      (i2c_sel),
        .i2c_busy     (i2c_busy),
        .i2c_done     (i2c_done),
        .i2c_ack_err  (i2c_ack_err),
        .i2c_rd_data  (i2c_rd_data),
        .angle_out    (angle_out),
        .rd_done      (rd_done),
        .err_flag     (err_flag),
        .active       (active)
`ifdef ENC_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Queue one read: what the stub answers with, which channel must be
    // granted, and the delivery the monitor should see (if any).
    task automatic applyStimulus(input int ch, input logic [15:0] data, input bit ack,
                                 input bit mute, input int delay, input bit deliver);
        done_t d;
        stub_q.push_back('{data, ack, mute, delay});
        exp_start_q.push_back(ch);
        if (deliver && !mute && !ack) begin
            d.ch    = ch;
            d.angle = data[11:0];
            exp_done_q.push_back(d);
        end
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        ch_enable = '0;
        err_clear = '0;
        repeat (3) @(posedge clock);
        #1;
        reset           = 1'b0;
        start_count     = 0;
        last_done_valid = 0;
    endtask

    task automatic waitStarts(input int n, input int bound);
        int k = 0;
        while (start_count < n && k < bound) begin
            @(posedge clock); #1;
            k++;
        end
        if (start_count < n) begin
            check_count++;
            $display("[TB] FAIL wait_start: starts=%0d required=%0d", start_count, n);
        end
    endtask

    task automatic waitIdle(input int bound);
        int k = 0;
        while ((active || i2c_busy) && k < bound) begin
            @(posedge clock); #1;
            k++;
        end
        if (active || i2c_busy) begin
            check_count++;
            $display("[TB] FAIL wait_idle: active=%0b busy=%0b required=0", active, i2c_busy);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_start"},  32'(i2c_start), 32'd0);
        checkOutput({tag, "_sel"},    32'(i2c_sel),   32'd0);
        checkOutput({tag, "_angle"},  32'(angle_out[31:0]), 32'd0);
        checkOutput({tag, "_done"},   32'(rd_done),   32'd0);
        checkOutput({tag, "_err"},    32'(err_flag),  32'd0);
        checkOutput({tag, "_active"}, 32'(active),    32'd0);
    endtask

    // Stub I2C master: answers each i2c_start with the next queued response.
    initial begin
        stub_t st;
        forever begin
            @(posedge clock); #1;
            if (i2c_start) begin
                if (stub_q.size() > 0) st = stub_q.pop_front();
                else st = '{16'h0, 1'b0, 1'b1, 0};
                if (!st.mute) begin
                    i2c_busy = 1'b1;
                    repeat (st.delay) @(posedge clock);
                    #1;
                    i2c_done        = 1'b1;
                    i2c_rd_data     = st.data;
                    i2c_ack_err     = st.ack;
                    stub_done_cycle = cycle;
                    @(posedge clock); #1;
                    i2c_done    = 1'b0;
                    i2c_ack_err = 1'b0;
                    i2c_busy    = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every launch and every delivery against the queues.
    always @(negedge clock) begin
        int    e;
        done_t d;
        if (!reset) begin
            if (i2c_start) begin
                start_count++;
                last_start_cycle = cycle;
                if (exp_start_q.size() == 0) begin
                    check_count++;
                    $display("[TB] FAIL unexpected_start: sel=%0d required=none", i2c_sel);
                end else begin
                    e = exp_start_q.pop_front();
                    checkOutput("grant_sel", 32'(i2c_sel), 32'(e));
                end
                checkOutput("dev_addr", 32'(i2c_dev_addr), 32'h36);
                checkOutput("reg_addr", 32'(i2c_reg_addr), 32'h0C);
                if (gap_check_en && last_done_valid)
                    checkOutput("gap_spacing", 32'(cycle - last_done_cycle), 32'(int'(GAP) + 3));
                last_done_valid = 0;
            end
            if (rd_done != '0) begin
                if (exp_done_q.size() == 0) begin
                    check_count++;
                    $display("[TB] FAIL unexpected_rd_done: rd_done=%b required=0000", rd_done);
                end else begin
                    d = exp_done_q.pop_front();
                    checkOutput("rd_done_bit", 32'(rd_done), 32'd1 << d.ch);
                    checkOutput("rd_angle", 32'(angle_out[d.ch*12 +: 12]), 32'(d.angle));
                    checkOutput("done_latency", 32'(cycle - stub_done_cycle), 32'd1);
                end
                last_done_cycle = cycle;
                last_done_valid = 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int order[6];
        int en_cycle;
        int e1;
        int e2;
        int k;
        order = '{0, 1, 3, 0, 1, 3};

        // Test 1: single channel read, reset values and latencies.
        resetDut();
        checkResetValues("t1_reset");
        applyStimulus(0, 16'h0ABC, 1'b0, 1'b0, 20, 1'b1);
        ch_enable = 4'b0001;
        en_cycle  = cycle;
        waitStarts(1, 20);
        checkOutput("t1_start_latency", 32'(last_start_cycle - en_cycle), 32'd2);
        ch_enable = 4'b0000;
        waitIdle(200);
        checkOutput("t1_angle", 32'(angle_out[11:0]), 32'hABC);
        checkOutput("t1_err", 32'(err_flag), 32'd0);

        // Test 2: round robin over 1011 with the enforced gap.
        resetDut();
        gap_check_en = 1;
        for (int n = 0; n < 6; n++)
            applyStimulus(order[n], {4'hF, 12'h100 + 12'(n * 17)}, 1'b0, 1'b0, 8, 1'b1);
        ch_enable = 4'b1011;
        waitStarts(6, 600);
        ch_enable = 4'b0000;
        waitIdle(200);
        gap_check_en = 0;
        checkOutput("t2_angle_ch0", 32'(angle_out[11:0]),  32'h133);
        checkOutput("t2_angle_ch1", 32'(angle_out[23:12]), 32'h144);
        checkOutput("t2_angle_ch2", 32'(angle_out[35:24]), 32'h000);
        checkOutput("t2_angle_ch3", 32'(angle_out[47:36]), 32'h155);

        // Test 3: timeouts on ch2, clear, and set-beats-clear.
        resetDut();
        applyStimulus(2, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(2, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(2, 16'h0123, 1'b0, 1'b0, 10, 1'b1);
        ch_enable = 4'b0100;
        waitStarts(1, 20);
        e1 = last_start_cycle;
        k  = 0;
        while (!err_flag[2] && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        checkOutput("t3_timeout_cycles", 32'(cycle - e1), 32'(int'(TIMEOUT) + 1));
        checkOutput("t3_err_flag", 32'(err_flag), 32'b0100);
        err_clear = 4'b0100;
        @(posedge clock); #1;
        err_clear = 4'b0000;
        checkOutput("t3_err_cleared", 32'(err_flag), 32'd0);
        waitStarts(2, 100);
        e2 = last_start_cycle;
        k  = 0;
        while (cycle < e2 + int'(TIMEOUT) && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        err_clear = 4'b0100;
        @(posedge clock); #1;
        err_clear = 4'b0000;
        checkOutput("t3_set_wins", 32'(err_flag), 32'b0100);
        waitStarts(3, 100);
        ch_enable = 4'b0000;
        waitIdle(200);
        checkOutput("t3_angle_ch2", 32'(angle_out[35:24]), 32'h123);

        // Test 4: NACK on ch1 keeps the old angle and flags the error.
        resetDut();
        applyStimulus(1, 16'h05A5, 1'b0, 1'b0, 10, 1'b1);
        applyStimulus(1, 16'h0FFF, 1'b1, 1'b0, 10, 1'b1);
        ch_enable = 4'b0010;
        waitStarts(2, 200);
        ch_enable = 4'b0000;
        waitIdle(200);
        checkOutput("t4_angle_ch1", 32'(angle_out[23:12]), 32'h5A5);
        checkOutput("t4_err_flag", 32'(err_flag), 32'b0010);

        // Test 5: reset during WAIT; the late i2c_done must be ignored.
        resetDut();
        applyStimulus(1, 16'h0777, 1'b0, 1'b0, 20, 1'b0);
        ch_enable = 4'b0010;
        waitStarts(1, 20);
        repeat (5) @(posedge clock);
        #1;
        reset     = 1'b1;
        ch_enable = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checkResetValues("t5_reset");
        repeat (30) @(posedge clock);
        #1;
        applyStimulus(0, 16'h0321, 1'b0, 1'b0, 10, 1'b1);
        ch_enable = 4'b1111;
        waitStarts(2, 20);
        ch_enable = 4'b0000;
        waitIdle(200);
        checkOutput("t5_angle_ch0", 32'(angle_out[11:0]),  32'h321);
        checkOutput("t5_angle_ch1", 32'(angle_out[23:12]), 32'h000);

`ifdef ENC_ERR_CNT_EN
        // Test 6: error counter saturation and clear.
        resetDut();
        for (int n = 0; n < 300; n++)
            applyStimulus(0, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        ch_enable = 4'b0001;
        waitStarts(300, 20000);
        ch_enable = 4'b0000;
        waitIdle(200);
        checkOutput("t6_err_count_sat", 32'(err_count[7:0]), 32'hFF);
        checkOutput("t6_err_count_ch1", 32'(err_count[15:8]), 32'h00);
        err_clear = 4'b0001;
        @(posedge clock); #1;
        err_clear = 4'b0000;
        checkOutput("t6_err_count_clr", 32'(err_count[7:0]), 32'h00);
        checkOutput("t6_err_flag_clr", 32'(err_flag), 32'd0);
`endif

        repeat (5) @(posedge clock);
        #1;
        checkOutput("start_queue_empty", 32'(exp_start_q.size()), 32'd0);
        checkOutput("done_queue_empty", 32'(exp_done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
